// File: rtl/spi_flash_pkg.sv
`timescale 1ns/1ps
// Shared opcodes, address width and FSM encoding for the SPI flash responder.
package spi_flash_pkg;
  localparam int ADDR_W = 24;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDID      = 8'h9F;
  localparam logic [7:0] OP_RDSR      = 8'h05;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, READ, RDID, RDSR, IGNORE
  } state_e;

  // Byte idx of the JEDEC ID, MSB first; anything past the third byte reads as zero.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    return id[23:16];
      2'd1:    return id[15:8];
      2'd2:    return id[7:0];
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/spi_in_sync.sv
`timescale 1ns/1ps
// Synchronizes sck/cs_n/mosi into the system clock and flags sck edges.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sck_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_n_o,
  output logic mosi_o
);
  logic [SYNC_STAGES-1:0] sck_q, cs_q, mosi_q;
  logic                   sck_dly_q;
  logic                   sck_s;

  assign sck_s = sck_q[SYNC_STAGES-1];

  // Reset values match an idle bus so no spurious edge or select appears on release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_q     <= '0;
      cs_q      <= '1;
      mosi_q    <= '0;
      sck_dly_q <= 1'b0;
    end else begin
      sck_q     <= (sck_q << 1)  | SYNC_STAGES'(sck_i);
      cs_q      <= (cs_q << 1)   | SYNC_STAGES'(cs_n_i);
      mosi_q    <= (mosi_q << 1) | SYNC_STAGES'(mosi_i);
      sck_dly_q <= sck_s;
    end
  end

  assign sck_rise_o = sck_s & ~sck_dly_q;
  assign sck_fall_o = ~sck_s & sck_dly_q;
  assign cs_n_o     = cs_q[SYNC_STAGES-1];
  assign mosi_o     = mosi_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_flash_responder.sv
`timescale 1ns/1ps
// SPI mode-0 flash read responder: READ/FAST_READ/RDID/RDSR with a one-byte
// prefetch from a byte-wide backing memory.
module spi_flash_responder import spi_flash_pkg::*; #(
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              underrun
);
  logic sck_rise, sck_fall, cs_n_s, mosi_s;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .sck_i      (spi_sck),
    .cs_n_i     (spi_cs_n),
    .mosi_i     (spi_mosi),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .cs_n_o     (cs_n_s),
    .mosi_o     (mosi_s)
  );

  state_e            state_q;
  logic [4:0]        bit_cnt_q;
  logic [22:0]       sh_in_q;
  logic [7:0]        sh_out_q;
  logic [2:0]        obit_q;
  logic [1:0]        id_idx_q;
  logic              fast_q;
  logic [ADDR_W-1:0] addr_q;
  logic              req_out_q, pf_valid_q;
  logic [7:0]        pf_data_q;
  logic              miso_q, oe_q, mem_req_q, underrun_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [23:0] sh_in_d;
  logic [7:0]  byte_d;

  assign sh_in_d = {sh_in_q, mosi_s};

  always_comb begin
    byte_d = 8'hFF;
    case (state_q)
      READ:    if (pf_valid_q) byte_d = pf_data_q;
      RDID:    byte_d = id_byte(JEDEC_ID, id_idx_q);
      RDSR:    byte_d = 8'h00;
      default: byte_d = 8'hFF;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sh_in_q    <= '0;
      sh_out_q   <= '0;
      obit_q     <= '0;
      id_idx_q   <= '0;
      fast_q     <= 1'b0;
      addr_q     <= '0;
      req_out_q  <= 1'b0;
      pf_valid_q <= 1'b0;
      pf_data_q  <= '0;
      miso_q     <= 1'b1;
      oe_q       <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      underrun_q <= 1'b0;
    end else begin
      mem_req_q  <= 1'b0;
      underrun_q <= 1'b0;
      if (mem_valid && req_out_q) begin
        pf_data_q  <= mem_rdata;
        pf_valid_q <= 1'b1;
        req_out_q  <= 1'b0;
      end
      // Deselect wins over everything, including a response landing this cycle.
      if (cs_n_s) begin
        state_q    <= IDLE;
        bit_cnt_q  <= '0;
        sh_in_q    <= '0;
        sh_out_q   <= '0;
        obit_q     <= '0;
        id_idx_q   <= '0;
        fast_q     <= 1'b0;
        req_out_q  <= 1'b0;
        pf_valid_q <= 1'b0;
        miso_q     <= 1'b1;
        oe_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q   <= CMD;
            bit_cnt_q <= '0;
          end
          CMD: if (sck_rise) begin
            sh_in_q   <= sh_in_d[22:0];
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_q <= '0;
              fast_q    <= (sh_in_d[7:0] == OP_FAST_READ);
              case (sh_in_d[7:0])
                OP_READ, OP_FAST_READ: state_q <= ADDR;
                OP_RDID: begin state_q <= RDID; oe_q <= 1'b1; end
                OP_RDSR: begin state_q <= RDSR; oe_q <= 1'b1; end
                default: state_q <= IGNORE;
              endcase
            end
          end
          ADDR: if (sck_rise) begin
            sh_in_q   <= sh_in_d[22:0];
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_q  <= '0;
              addr_q     <= sh_in_d;
              mem_addr_q <= sh_in_d;
              mem_req_q  <= 1'b1;
              req_out_q  <= 1'b1;
              if (fast_q) state_q <= DUMMY;
              else begin state_q <= READ; oe_q <= 1'b1; end
            end
          end
          DUMMY: if (sck_rise) begin
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              state_q <= READ;
              oe_q    <= 1'b1;
            end
          end
          READ, RDID, RDSR: if (sck_fall) begin
            obit_q <= obit_q + 3'd1;
            if (obit_q == 3'd0) begin
              miso_q   <= byte_d[7];
              sh_out_q <= {byte_d[6:0], 1'b0};
              if (state_q == READ) begin
                if (pf_valid_q) begin
                  pf_valid_q <= 1'b0;
                  addr_q     <= addr_q + 24'd1;
                  mem_addr_q <= addr_q + 24'd1;
                  mem_req_q  <= 1'b1;
                  req_out_q  <= 1'b1;
                end else begin
                  underrun_q <= 1'b1;
                end
              end
              if (state_q == RDID && id_idx_q != 2'd3) id_idx_q <= id_idx_q + 2'd1;
            end else begin
              miso_q   <= sh_out_q[7];
              sh_out_q <= {sh_out_q[6:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign underrun    = underrun_q;
  assign busy        = ~cs_n_s;
endmodule

// File: tb/tb_spi_flash_responder.sv
`timescale 1ns/1ps
// Directed bench: a table of flash transactions plus hand-written abort,
// underrun and async-reset sequences. Backing memory holds memory[n] = n[7:0].
module tb_spi_flash_responder;
  localparam int HALF = 8;  // clocks per sck half period

  logic        clock = 1'b0, reset_n = 1'b0;
  logic        spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic        mem_valid = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        spi_miso, spi_miso_oe, mem_req, busy, underrun;
  logic [23:0] mem_addr;

  int          n_cmp = 0, n_err = 0, lat = 1, ucnt = 0;
  logic [23:0] aq[$];

  always #5 clock = ~clock;

  spi_flash_responder #(.JEDEC_ID(24'hEF4016), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .busy(busy), .underrun(underrun)
  );

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory model: logs each request address, answers lat cycles later.
  initial begin
    logic [23:0] a;
    forever begin
      @(posedge clock); #1;
      if (mem_req === 1'b1) begin
        a = mem_addr;
        aq.push_back(a);
        repeat (lat) begin @(posedge clock); #1; end
        mem_valid = 1'b1;
        mem_rdata = a[7:0];
        @(posedge clock); #1;
        mem_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock); #1;
      if (underrun === 1'b1) ucnt++;
    end
  end

  // One sck bit: falling edge (except first), mosi set, sample miso just before the rise.
  task automatic bit_x(input logic mo, output logic mi, output logic oe);
    spi_sck  = 1'b0;
    spi_mosi = mo;
    tick(HALF);
    mi = spi_miso;
    oe = spi_miso_oe;
    spi_sck = 1'b1;
    tick(HALF);
  endtask

  task automatic send(input logic [31:0] v, input int nb);
    logic mi, oe;
    for (int i = nb - 1; i >= 0; i--) bit_x(v[i], mi, oe);
  endtask

  task automatic recv(input logic exp_oe, output logic [7:0] b, output int bad);
    logic mi, oe;
    logic [7:0] r;
    int nb;
    nb = 0;
    r  = 8'h00;
    for (int j = 7; j >= 0; j--) begin
      bit_x(1'b0, mi, oe);
      r[j] = mi;
      if (oe !== exp_oe) nb++;
    end
    b   = r;
    bad = nb;
  endtask

  task automatic start();
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  // Deselect while sck is still high, so the trailing fall lands outside the frame.
  task automatic stop();
    spi_cs_n = 1'b1;
    tick(6);
    spi_sck = 1'b0;
    tick(12);
  endtask

  typedef struct {
    string            nm;
    logic [7:0]       op;
    logic [23:0]      addr;
    logic             use_addr;
    int               ndummy;
    int               nbytes;
    logic [3:0][7:0]  exp;
    logic             exp_oe;
    int               nreq;
    logic [2:0][23:0] ea;
  } vec_t;

  vec_t v[6];

  task automatic setv(input int i, input string nm, input logic [7:0] op, input logic [23:0] addr,
                      input logic use_addr, input int ndummy, input int nbytes,
                      input logic [31:0] exp, input logic exp_oe, input int nreq,
                      input logic [71:0] ea);
    v[i].nm = nm; v[i].op = op; v[i].addr = addr; v[i].use_addr = use_addr;
    v[i].ndummy = ndummy; v[i].nbytes = nbytes; v[i].exp = exp; v[i].exp_oe = exp_oe;
    v[i].nreq = nreq; v[i].ea = ea;
  endtask

  initial begin
    logic [7:0] b;
    int bad, dbad;
    logic mi, oe;

    // exp packs byte0 in the low byte; ea packs the first request in the low 24 bits
    setv(0, "read",   8'h03, 24'h000010, 1'b1, 0, 2, 32'h0000_1110, 1'b1, 3, {24'h000012, 24'h000011, 24'h000010});
    setv(1, "fast",   8'h0B, 24'h000100, 1'b1, 8, 1, 32'h0000_0000, 1'b1, 2, {24'h000000, 24'h000101, 24'h000100});
    setv(2, "wrap",   8'h03, 24'hFFFFFF, 1'b1, 0, 2, 32'h0000_00FF, 1'b1, 3, {24'h000001, 24'h000000, 24'hFFFFFF});
    setv(3, "rdid",   8'h9F, 24'h000000, 1'b0, 0, 4, 32'h0016_40EF, 1'b1, 0, 72'h0);
    setv(4, "rdsr",   8'h05, 24'h000000, 1'b0, 0, 2, 32'h0000_0000, 1'b1, 0, 72'h0);
    setv(5, "ignore", 8'hAB, 24'h000000, 1'b0, 0, 2, 32'h0000_0000, 1'b0, 0, 72'h0);

    // Reset state, with cs_n driven low to show the synchronizer is held idle.
    tick(2);
    spi_cs_n = 1'b0;
    tick(4);
    chk("rst miso", {31'h0, spi_miso}, 32'h1);
    chk("rst oe", {31'h0, spi_miso_oe}, 32'h0);
    chk("rst req", {31'h0, mem_req}, 32'h0);
    chk("rst addr", {8'h0, mem_addr}, 32'h0);
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst underrun", {31'h0, underrun}, 32'h0);
    spi_cs_n = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(6);

    for (int i = 0; i < 6; i++) begin
      aq.delete();
      start();
      send({24'h0, v[i].op}, 8);
      if (v[i].use_addr) send({8'h0, v[i].addr}, 24);
      dbad = 0;
      for (int d = 0; d < v[i].ndummy; d++) begin
        bit_x(1'b0, mi, oe);
        if (oe !== 1'b0) dbad++;
      end
      if (v[i].ndummy > 0) chk({v[i].nm, " dummy oe"}, dbad, 0);
      for (int k = 0; k < v[i].nbytes; k++) begin
        recv(v[i].exp_oe, b, bad);
        chk($sformatf("%s oe byte%0d", v[i].nm, k), bad, 0);
        if (v[i].exp_oe) chk($sformatf("%s byte%0d", v[i].nm, k), {24'h0, b}, {24'h0, v[i].exp[k]});
      end
      stop();
      chk({v[i].nm, " nreq"}, aq.size(), v[i].nreq);
      for (int k = 0; k < v[i].nreq; k++)
        chk($sformatf("%s mem_addr%0d", v[i].nm, k),
            (aq.size() > k) ? {8'h0, aq[k]} : 32'hFFFF_FFFF, {8'h0, v[i].ea[k]});
    end

    // Abort after 13 address bits, then a status read must still frame correctly.
    aq.delete();
    start();
    chk("abort busy on", {31'h0, busy}, 32'h1);
    send(32'h03, 8);
    send(32'h1ABC, 13);
    spi_cs_n = 1'b1;
    tick(4);
    chk("abort busy off", {31'h0, busy}, 32'h0);
    chk("abort oe off", {31'h0, spi_miso_oe}, 32'h0);
    spi_sck = 1'b0;
    tick(12);
    start();
    send(32'h05, 8);
    recv(1'b1, b, bad);
    stop();
    chk("abort rdsr byte", {24'h0, b}, 32'h0);
    chk("abort rdsr oe", bad, 0);
    chk("abort nreq", aq.size(), 0);

    // Underrun: response arrives long after the byte boundary and after deselect.
    lat  = 150;
    ucnt = 0;
    start();
    send(32'h03, 8);
    send(32'h000020, 24);
    recv(1'b1, b, bad);
    stop();
    chk("underrun byte", {24'h0, b}, 32'hFF);
    tick(200);
    chk("underrun pulses", ucnt, 1);
    lat = 1;
    start();
    send(32'h03, 8);
    send(32'h000030, 24);
    recv(1'b1, b, bad);
    stop();
    chk("post underrun byte", {24'h0, b}, 32'h30);
    chk("post underrun pulses", ucnt, 1);

    // Async reset mid-READ, asserted between clock edges.
    start();
    send(32'h03, 8);
    send(32'h000040, 24);
    recv(1'b1, b, bad);
    chk("pre-reset byte", {24'h0, b}, 32'h40);
    send(32'h0, 3);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst miso", {31'h0, spi_miso}, 32'h1);
    chk("arst oe", {31'h0, spi_miso_oe}, 32'h0);
    chk("arst req", {31'h0, mem_req}, 32'h0);
    chk("arst addr", {8'h0, mem_addr}, 32'h0);
    chk("arst busy", {31'h0, busy}, 32'h0);
    chk("arst underrun", {31'h0, underrun}, 32'h0);
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    tick(5);
    reset_n = 1'b1;
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
